// File: rtl/mod_controller_poll_scheduler.sv
// -----------------------------------------------------------------------------
// mod_controller_poll_scheduler
//
// Runs the NES serial read protocol for two controller ports that share one
// latch line and one pulse line. A poll starts on each falling edge of vsync.
// Each poll shifts in NUM_BITS button bits per port. Both button bytes are
// then committed in the same cycle, so software never sees a mixed frame.
//
// Ports:
//   in_clk_12_mhz        system clock (12 MHz)
//   in_reset             asynchronous, active-high reset
//   in_vsync             VGA vsync, active-low, asynchronous to in_clk_12_mhz
//   in_poll_enable       gates new polls; a poll already running still completes
//   in_controller0_data  port 0 serial data, active-low (0 = pressed)
//   in_controller1_data  port 1 serial data, active-low
//   out_controller_latch shared latch line
//   out_controller_pulse shared pulse (clock) line
//   out_buttons0/1       committed buttons, 1 = pressed
//                        (bit7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down,
//                         1=Left, 0=Right)
//   out_pressed0/1       0->1 transitions from the last commit; non-zero only
//                        while out_frame_done is high
//   out_frame_done       one-cycle strobe in the cycle after the commit
//   out_busy             high while a poll is in progress (LATCH..COMMIT)
//   out_overrun          one-cycle strobe when a trigger arrives while busy
// -----------------------------------------------------------------------------
module mod_controller_poll_scheduler #(
  parameter int LATCH_CLKS      = 144,
  parameter int HALF_PULSE_CLKS = 72,
  parameter int NUM_BITS        = 8
) (
  input  logic                in_clk_12_mhz,
  input  logic                in_reset,
  input  logic                in_vsync,
  input  logic                in_poll_enable,
  input  logic                in_controller0_data,
  input  logic                in_controller1_data,
  output logic                out_controller_latch,
  output logic                out_controller_pulse,
  output logic [NUM_BITS-1:0] out_buttons0,
  output logic [NUM_BITS-1:0] out_buttons1,
  output logic [NUM_BITS-1:0] out_pressed0,
  output logic [NUM_BITS-1:0] out_pressed1,
  output logic                out_frame_done,
  output logic                out_busy,
  output logic                out_overrun
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LATCH      = 3'd1;
  localparam logic [2:0] ST_SETTLE     = 3'd2;
  localparam logic [2:0] ST_PULSE_HIGH = 3'd3;
  localparam logic [2:0] ST_PULSE_LOW  = 3'd4;
  localparam logic [2:0] ST_COMMIT     = 3'd5;

  localparam int CNT_MAX = (LATCH_CLKS > HALF_PULSE_CLKS) ? LATCH_CLKS : HALF_PULSE_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BIT_W   = $clog2(NUM_BITS) + 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PULSE_CLKS - 1);
  localparam logic [BIT_W-1:0] BITS_LAST  = BIT_W'(NUM_BITS - 1);

  logic                vs_meta, vs_sync, vs_prev;
  logic                trigger;
  logic [2:0]          state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                sample;
  logic [NUM_BITS-1:0] shift0, shift1;

  // vsync is idle-high, so the synchronizer resets to 1 to avoid a false
  // trigger when reset is released.
  assign trigger = vs_prev & ~vs_sync;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      ST_IDLE:       if (trigger && in_poll_enable) state_next = ST_LATCH;
      ST_LATCH:      if (cnt == LATCH_LAST) state_next = ST_SETTLE;
      ST_SETTLE:     if (cnt == HALF_LAST) begin
                       sample     = 1'b1;
                       state_next = ST_PULSE_HIGH;
                     end
      ST_PULSE_HIGH: if (cnt == HALF_LAST) state_next = ST_PULSE_LOW;
      ST_PULSE_LOW:  if (cnt == HALF_LAST) begin
                       sample     = 1'b1;
                       // The last bit is taken here, so no extra pulse is issued.
                       state_next = (bit_cnt == BITS_LAST) ? ST_COMMIT : ST_PULSE_HIGH;
                     end
      ST_COMMIT:     state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop in this block sees the pre-edge values of the others.
  always_ff @(posedge in_clk_12_mhz or posedge in_reset) begin
    if (in_reset) begin
      vs_meta              <= 1'b1;
      vs_sync              <= 1'b1;
      vs_prev              <= 1'b1;
      state                <= ST_IDLE;
      cnt                  <= '0;
      bit_cnt              <= '0;
      shift0               <= '0;
      shift1               <= '0;
      out_controller_latch <= 1'b0;
      out_controller_pulse <= 1'b0;
      out_buttons0         <= '0;
      out_buttons1         <= '0;
      out_pressed0         <= '0;
      out_pressed1         <= '0;
      out_frame_done       <= 1'b0;
      out_busy             <= 1'b0;
      out_overrun          <= 1'b0;
    end else begin
      vs_meta <= in_vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;

      state <= state_next;

      // The phase counter restarts on every state change and rests at 0 in IDLE.
      if (state_next != state || state == ST_IDLE) cnt <= '0;
      else                                         cnt <= cnt + CNT_W'(1);

      if (state == ST_IDLE) bit_cnt <= '0;
      else if (sample)      bit_cnt <= bit_cnt + BIT_W'(1);

      // The first bit sampled (A) ends up in the MSB after NUM_BITS shifts.
      if (sample) begin
        shift0 <= {shift0[NUM_BITS-2:0], ~in_controller0_data};
        shift1 <= {shift1[NUM_BITS-2:0], ~in_controller1_data};
      end

      // Line outputs follow the next state so they are registered and aligned
      // with the state they belong to.
      out_controller_latch <= (state_next == ST_LATCH);
      out_controller_pulse <= (state_next == ST_PULSE_HIGH);
      out_busy             <= (state_next != ST_IDLE);

      // COMMIT also counts as busy for overrun purposes.
      out_overrun <= trigger && (state != ST_IDLE);

      if (state == ST_COMMIT) begin
        out_buttons0   <= shift0;
        out_buttons1   <= shift1;
        out_pressed0   <= shift0 & ~out_buttons0;
        out_pressed1   <= shift1 & ~out_buttons1;
        out_frame_done <= 1'b1;
      end else begin
        out_pressed0   <= '0;
        out_pressed1   <= '0;
        out_frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_controller_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mod_controller_poll_scheduler
//
// Drives mod_controller_poll_scheduler with shortened timing. Two behavioural
// NES pads answer the shared latch/pulse lines. A monitor checks the line
// protocol, and a frame-level model predicts buttons and pressed masks.
// -----------------------------------------------------------------------------
module tb_mod_controller_poll_scheduler;

  localparam int LATCH_CLKS      = 4;
  localparam int HALF_PULSE_CLKS = 2;
  localparam int NUM_BITS        = 8;
  localparam int POLL_LEN        = LATCH_CLKS + HALF_PULSE_CLKS + 14 * HALF_PULSE_CLKS + 1;

  logic       in_clk_12_mhz = 1'b0;
  logic       in_reset      = 1'b1;
  logic       in_vsync      = 1'b1;
  logic       in_poll_enable = 1'b1;
  logic       in_controller0_data;
  logic       in_controller1_data;
  logic       out_controller_latch;
  logic       out_controller_pulse;
  logic [7:0] out_buttons0, out_buttons1;
  logic [7:0] out_pressed0, out_pressed1;
  logic       out_frame_done;
  logic       out_busy;
  logic       out_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  mod_controller_poll_scheduler #(
    .LATCH_CLKS     (LATCH_CLKS),
    .HALF_PULSE_CLKS(HALF_PULSE_CLKS),
    .NUM_BITS       (NUM_BITS)
  ) dut (
    .in_clk_12_mhz       (in_clk_12_mhz),
    .in_reset            (in_reset),
    .in_vsync            (in_vsync),
    .in_poll_enable      (in_poll_enable),
    .in_controller0_data (in_controller0_data),
    .in_controller1_data (in_controller1_data),
    .out_controller_latch(out_controller_latch),
    .out_controller_pulse(out_controller_pulse),
    .out_buttons0        (out_buttons0),
    .out_buttons1        (out_buttons1),
    .out_pressed0        (out_pressed0),
    .out_pressed1        (out_pressed1),
    .out_frame_done      (out_frame_done),
    .out_busy            (out_busy),
    .out_overrun         (out_overrun)
  );

  always #42 in_clk_12_mhz = ~in_clk_12_mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pad model: latch high reloads the button snapshot, each pulse rise moves to
  // the next button. Raw bytes are A-first and active-low.
  // ---------------------------------------------------------------------------
  logic [7:0] pad_raw0 = 8'hFF;
  logic [7:0] pad_raw1 = 8'hFF;
  int         pad_idx  = 0;

  always @(posedge out_controller_latch or posedge out_controller_pulse) begin
    if (out_controller_latch) pad_idx = 0;
    else                      pad_idx = pad_idx + 1;
  end

  always_comb begin
    in_controller0_data = 1'b1;
    in_controller1_data = 1'b1;
    if (pad_idx < 8) begin
      in_controller0_data = pad_raw0[7 - pad_idx];
      in_controller1_data = pad_raw1[7 - pad_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol monitor, sampled on the falling clock edge.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int latch_run = 0, pulse_run = 0, overrun_run = 0;
  int pulses_in_poll = 0, latch_rise_cyc = 0;
  int latch_rises = 0, overrun_pulses = 0, done_pulses = 0;

  always @(negedge in_clk_12_mhz) begin
    cyc++;
    if (in_reset) begin
      latch_run   = 0;
      pulse_run   = 0;
      overrun_run = 0;
    end else begin
      check("latch_pulse_overlap", 32'(out_controller_latch & out_controller_pulse), 32'd0);
      if (!out_frame_done) check("pressed_idle", {16'd0, out_pressed1, out_pressed0}, 32'd0);

      if (out_controller_latch) begin
        if (latch_run == 0) begin
          latch_rises++;
          latch_rise_cyc = cyc;
          pulses_in_poll = 0;
          check("busy_at_latch", 32'(out_busy), 32'd1);
        end
        latch_run++;
      end else if (latch_run != 0) begin
        check("latch_width", latch_run, LATCH_CLKS);
        latch_run = 0;
      end

      if (out_controller_pulse) begin
        if (pulse_run == 0) pulses_in_poll++;
        pulse_run++;
      end else if (pulse_run != 0) begin
        check("pulse_width", pulse_run, HALF_PULSE_CLKS);
        pulse_run = 0;
      end

      if (out_overrun) begin
        if (overrun_run == 0) overrun_pulses++;
        overrun_run++;
      end else if (overrun_run != 0) begin
        check("overrun_width", overrun_run, 1);
        overrun_run = 0;
      end

      if (out_frame_done) begin
        done_pulses++;
        check("poll_length", cyc - latch_rise_cyc, POLL_LEN);
        check("pulse_count", pulses_in_poll, NUM_BITS - 1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-level model and stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] model_btn0 = 8'h00;
  logic [7:0] model_btn1 = 8'h00;

  task automatic vsync_fall();
    @(negedge in_clk_12_mhz);
    #7 in_vsync = 1'b0;
    repeat (4) @(negedge in_clk_12_mhz);
    #7 in_vsync = 1'b1;
  endtask

  task automatic run_poll(input logic [7:0] raw0, input logic [7:0] raw1,
                          input bit inject_overrun, input bit drop_enable);
    int         r0, o0, d0;
    bit         seen;
    logic [7:0] exp0, exp1;
    r0 = latch_rises;
    o0 = overrun_pulses;
    d0 = done_pulses;
    exp0 = ~raw0;
    exp1 = ~raw1;
    pad_raw0 = raw0;
    pad_raw1 = raw1;
    vsync_fall();
    repeat (6) @(negedge in_clk_12_mhz);
    check("buttons0_hold", {24'd0, out_buttons0}, {24'd0, model_btn0});
    check("buttons1_hold", {24'd0, out_buttons1}, {24'd0, model_btn1});
    if (drop_enable) in_poll_enable = 1'b0;
    if (inject_overrun) vsync_fall();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge in_clk_12_mhz);
      if (out_frame_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("buttons0", {24'd0, out_buttons0}, {24'd0, exp0});
      check("buttons1", {24'd0, out_buttons1}, {24'd0, exp1});
      check("pressed0", {24'd0, out_pressed0}, {24'd0, exp0 & ~model_btn0});
      check("pressed1", {24'd0, out_pressed1}, {24'd0, exp1 & ~model_btn1});
      check("busy_after_commit", 32'(out_busy), 32'd0);
      @(negedge in_clk_12_mhz);
      check("done_one_cycle", 32'(out_frame_done), 32'd0);
    end
    model_btn0 = exp0;
    model_btn1 = exp1;
    in_poll_enable = 1'b1;
    repeat (8) @(negedge in_clk_12_mhz);
    check("polls_started", latch_rises - r0, 1);
    check("overruns", overrun_pulses - o0, inject_overrun ? 1 : 0);
    check("dones", done_pulses - d0, 1);
  endtask

  initial begin
    int  r0, o0;
    bit  seen;

    // Reset state
    repeat (3) @(negedge in_clk_12_mhz);
    check("rst_latch", 32'(out_controller_latch), 32'd0);
    check("rst_pulse", 32'(out_controller_pulse), 32'd0);
    check("rst_outputs", {out_buttons1, out_buttons0, out_pressed1, out_pressed0}, 32'd0);
    check("rst_strobes", {29'd0, out_frame_done, out_busy, out_overrun}, 32'd0);
    #5 in_reset = 1'b0;
    repeat (4) @(negedge in_clk_12_mhz);
    check("idle_after_reset", {30'd0, out_busy, out_controller_latch}, 32'd0);

    // Port 0 = 0x5A raw, port 1 unplugged
    run_poll(8'h5A, 8'hFF, 1'b0, 1'b0);

    // Reset in the middle of a pulse-high phase
    pad_raw0 = 8'h00;
    vsync_fall();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge in_clk_12_mhz);
      if (out_controller_pulse) seen = 1'b1;
    end
    check("reached_pulse_high", 32'(seen), 32'd1);
    #5 in_reset = 1'b1;
    #1;
    check("mid_rst_latch", 32'(out_controller_latch), 32'd0);
    check("mid_rst_pulse", 32'(out_controller_pulse), 32'd0);
    check("mid_rst_busy", 32'(out_busy), 32'd0);
    check("mid_rst_buttons", {16'd0, out_buttons1, out_buttons0}, 32'd0);
    model_btn0 = 8'h00;
    model_btn1 = 8'h00;
    repeat (3) @(negedge in_clk_12_mhz);
    #5 in_reset = 1'b0;
    repeat (6) @(negedge in_clk_12_mhz);
    check("idle_after_mid_rst", {30'd0, out_busy, out_controller_latch}, 32'd0);

    // Pressed-edge sequence: none, then A+Right, then held
    run_poll(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_poll(8'h7E, 8'hFF, 1'b0, 1'b0);
    run_poll(8'h7E, 8'hFF, 1'b0, 1'b0);

    // Second vsync fall during a poll
    run_poll(8'h3C, 8'h0F, 1'b1, 1'b0);

    // Enable held low over a vsync fall
    r0 = latch_rises;
    o0 = overrun_pulses;
    in_poll_enable = 1'b0;
    vsync_fall();
    repeat (40) @(negedge in_clk_12_mhz);
    check("disabled_no_poll", latch_rises - r0, 0);
    check("disabled_no_overrun", overrun_pulses - o0, 0);
    in_poll_enable = 1'b1;

    // Enable dropped mid-poll
    run_poll(8'hC3, 8'h55, 1'b0, 1'b1);

    // Randomized polls
    for (int n = 0; n < 24; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_poll(ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
